// File: rtl/stopwatch_lap.sv
// MM:SS stopwatch core with a prescaler, start/stop/clear control and a lap-capture FIFO.
// Define STOPWATCH_COUNTDOWN_EN to add load/countdown ports and the DONE state.
module stopwatch_lap #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int MIN_WIDTH     = 8,
  parameter int LAP_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             clear,
  input  logic                             lap,
  output logic [MIN_WIDTH-1:0]             minutes,
  output logic [5:0]                       seconds,
  output logic [1:0]                       status,
  output logic                             rollover,
  output logic                             lap_valid,
  output logic [MIN_WIDTH+5:0]             lap_data,
  input  logic                             lap_ready,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic                             mode_down,
  input  logic                             load,
  input  logic [MIN_WIDTH-1:0]             load_min,
  input  logic [5:0]                       load_sec,
  output logic                             done,
`endif
  output logic                             lap_overflow
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam int DW = MIN_WIDTH + 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [MIN_WIDTH-1:0]  min_q, min_d;
  logic [5:0]            sec_q, sec_d;
  logic                  rollover_q, rollover_d;
  logic                  ovf_q, ovf_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_inc;
  logic [CW-1:0]         count_q, count_d;
  logic [DW-1:0]         head_q, head_d;
  logic [DW-1:0]         mem [LAP_DEPTH];
  logic [DW-1:0]         push_data;
  logic                  tick, push, pop, lap_req;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic                  mode_q, mode_d;
  logic                  done_q, done_d;
`endif

  assign push_data = {min_q, sec_q};
  assign rd_inc    = rd_ptr_q + AW'(1);
  assign lap_req   = lap && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
  assign pop       = (count_q != '0) && lap_ready;
  assign push      = lap_req && ((count_q != CW'(LAP_DEPTH)) || pop);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    min_d      = min_q;
    sec_d      = sec_q;
    rollover_d = 1'b0;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_d     = head_q;
    tick       = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
    mode_d     = mode_q;
    done_d     = 1'b0;
`endif

    if (clear) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      min_d    = '0;
      sec_d    = '0;
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
`ifdef STOPWATCH_COUNTDOWN_EN
          if (load) begin
            min_d = load_min;
            sec_d = (load_sec > 6'd59) ? 6'd59 : load_sec;
          end
          if (start && !stop && !(mode_down && min_q == '0 && sec_q == '0)) begin
            state_d = ST_RUN;
            presc_d = '0;
            mode_d  = mode_down;
          end
`else
          if (start && !stop) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
`endif
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
            presc_d = '0;
            tick    = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: if (start && !stop) state_d = ST_RUN;
        ST_DONE:  ;
        default:  state_d = ST_IDLE;
      endcase

      if (tick) begin
`ifdef STOPWATCH_COUNTDOWN_EN
        if (mode_q) begin
          if (sec_q == 6'd0) begin
            sec_d = 6'd59;
            min_d = min_q - MIN_WIDTH'(1);
          end else begin
            sec_d = sec_q - 6'd1;
          end
          // Reaching 0:00 latches DONE; ticks stop because DONE never advances.
          if (min_q == '0 && sec_q == 6'd1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else
`endif
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == '1) begin
            min_d      = '0;
            rollover_d = 1'b1;
          end else begin
            min_d = min_q + MIN_WIDTH'(1);
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end

      if (lap_req && !push) ovf_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_inc;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // Head register tracks what the FIFO head will be after this edge.
      if (pop)                  head_d = (count_q == CW'(1)) ? push_data : mem[rd_inc];
      else if (count_q == '0)   head_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      rollover_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
`ifdef STOPWATCH_COUNTDOWN_EN
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q    <= state_d;
      presc_q    <= presc_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      rollover_q <= rollover_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
`ifdef STOPWATCH_COUNTDOWN_EN
      mode_q     <= mode_d;
      done_q     <= done_d;
`endif
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) mem[wr_ptr_q] <= push_data;
  end

  assign minutes      = min_q;
  assign seconds      = sec_q;
  assign status       = state_q;
  assign rollover     = rollover_q;
  assign lap_valid    = (count_q != '0);
  assign lap_data     = head_q;
  assign lap_count    = count_q;
  assign lap_overflow = ovf_q;
`ifdef STOPWATCH_COUNTDOWN_EN
  assign done         = done_q;
`endif

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench: instance A (1 tick/s, 2-bit minutes) and B (4 ticks/s) share stimulus.
module tb_stopwatch_lap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, clear, lap, lap_ready;
  logic [1:0] a_min, a_status;
  logic [5:0] a_sec;
  logic       a_roll, a_lv, a_ovf;
  logic [7:0] a_ld;
  logic [2:0] a_cnt;
  logic [7:0] b_min;
  logic [5:0] b_sec;
  logic [1:0] b_status;
  logic       b_roll, b_lv, b_ovf;
  logic [13:0] b_ld;
  logic [2:0] b_cnt;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic       mode_down, load, a_done, b_done;
  logic [7:0] load_min;
  logic [5:0] load_sec;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] lap_exp_q [$];

  stopwatch_lap #(.TICKS_PER_SEC(1), .MIN_WIDTH(2), .LAP_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .minutes(a_min), .seconds(a_sec), .status(a_status), .rollover(a_roll),
    .lap_valid(a_lv), .lap_data(a_ld), .lap_ready(lap_ready), .lap_count(a_cnt),
`ifdef STOPWATCH_COUNTDOWN_EN
    .mode_down(mode_down), .load(load), .load_min(load_min[1:0]), .load_sec(load_sec),
    .done(a_done),
`endif
    .lap_overflow(a_ovf)
  );

  stopwatch_lap #(.TICKS_PER_SEC(4), .MIN_WIDTH(8), .LAP_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .minutes(b_min), .seconds(b_sec), .status(b_status), .rollover(b_roll),
    .lap_valid(b_lv), .lap_data(b_ld), .lap_ready(lap_ready), .lap_count(b_cnt),
`ifdef STOPWATCH_COUNTDOWN_EN
    .mode_down(mode_down), .load(load), .load_min(load_min), .load_sec(load_sec),
    .done(b_done),
`endif
    .lap_overflow(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ctl(input logic s, input logic p, input logic c, input logic l, input logic r);
    start = s; stop = p; clear = c; lap = l; lap_ready = r;
    step(1);
    start = 0; stop = 0; clear = 0; lap = 0; lap_ready = 0;
  endtask

  task automatic pop_a(input string tag);
    logic [7:0] exp;
    if (lap_exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = lap_exp_q.pop_front();
      check({tag, "_valid"}, a_lv, 1);
      check({tag, "_data"}, a_ld, exp);
      ctl(0, 0, 0, 0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; stop = 0; clear = 0; lap = 0; lap_ready = 0;
`ifdef STOPWATCH_COUNTDOWN_EN
    mode_down = 0; load = 0; load_min = 0; load_sec = 0;
`endif
    step(2);
    rst = 0;
    check("rst_status", a_status, 0);
    check("rst_min", a_min, 0);
    check("rst_sec", a_sec, 0);
    check("rst_valid", a_lv, 0);
    check("rst_count", a_cnt, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_roll", a_roll, 0);

    // Count up: 75 running edges at 1 tick/s is 1:15; B at 4 ticks/s sees 18 s.
    ctl(1, 0, 0, 0, 0);
    step(75);
    check("run75_min", a_min, 1);
    check("run75_sec", a_sec, 15);
    check("run75_status", a_status, 1);
    check("run75_b_sec", b_sec, 18);
    check("run75_b_min", b_min, 0);

    // Rollover at 3:59 -> 0:00 for a 2-bit minutes counter.
    step(164);
    check("pre_wrap_min", a_min, 3);
    check("pre_wrap_sec", a_sec, 59);
    check("pre_wrap_roll", a_roll, 0);
    step(1);
    check("wrap_min", a_min, 0);
    check("wrap_sec", a_sec, 0);
    check("wrap_roll", a_roll, 1);
    check("wrap_status", a_status, 1);
    step(1);
    check("post_wrap_roll", a_roll, 0);
    check("post_wrap_sec", a_sec, 1);
    ctl(0, 0, 1, 0, 0);
    check("clear_status", a_status, 0);

    // Pause/resume keeps the prescaler phase on B.
    ctl(1, 0, 0, 0, 0);
    step(10);
    check("b_run10_sec", b_sec, 2);
    check("b_run10_status", b_status, 1);
    ctl(0, 1, 0, 0, 0);
    check("b_stop_status", b_status, 2);
    check("b_stop_sec", b_sec, 2);
    step(20);
    check("b_paused_sec", b_sec, 2);
    ctl(1, 0, 0, 0, 0);
    check("b_resume_status", b_status, 1);
    step(5);
    check("b_resume5_sec", b_sec, 3);
    step(1);
    check("b_resume6_sec", b_sec, 4);
    ctl(0, 0, 1, 0, 0);

    // Lap FIFO on A: captures at 1,3,5,7 s fill it.
    ctl(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      lap_exp_q.push_back(8'(2 * i + 1));
      ctl(0, 0, 0, 1, 0);
    end
    check("full_count", a_cnt, 4);
    check("full_ovf", a_ovf, 0);
    // Push and pop together while full: head 1 leaves, 9 enters, no overflow.
    step(1);
    lap_exp_q.push_back(8'd9);
    check("pp_head", a_ld, lap_exp_q.pop_front());
    ctl(0, 0, 0, 1, 1);
    check("pp_count", a_cnt, 4);
    check("pp_ovf", a_ovf, 0);
    step(1);
    ctl(0, 0, 0, 1, 0);
    check("drop_ovf", a_ovf, 1);
    check("drop_count", a_cnt, 4);
    for (int i = 0; i < 4; i++) pop_a($sformatf("pop%0d", i));
    check("drained_valid", a_lv, 0);
    check("drained_count", a_cnt, 0);
    check("sticky_ovf", a_ovf, 1);
    ctl(0, 0, 1, 0, 0);
    check("clr_valid", a_lv, 0);
    check("clr_ovf", a_ovf, 0);
    check("clr_min", a_min, 0);
    check("clr_sec", a_sec, 0);
    check("clr_status", a_status, 0);

    // Simultaneous controls.
    ctl(1, 0, 0, 0, 0);
    step(3);
    ctl(1, 1, 0, 0, 0);
    check("startstop_status", a_status, 2);
    check("startstop_sec", a_sec, 3);
    ctl(0, 0, 1, 1, 0);
    check("clrlap_count", a_cnt, 0);
    check("clrlap_valid", a_lv, 0);
    check("clrlap_status", a_status, 0);
    ctl(1, 0, 0, 0, 0);
    step(2);
    lap_exp_q.push_back(8'd2);
    ctl(0, 0, 0, 1, 1);
    check("empty_pp_count", a_cnt, 1);
    pop_a("empty_pp");
    ctl(0, 0, 0, 1, 0);
    step(2);
    rst = 1;
    step(1);
    rst = 0;
    check("midrst_status", a_status, 0);
    check("midrst_min", a_min, 0);
    check("midrst_sec", a_sec, 0);
    check("midrst_valid", a_lv, 0);
    check("midrst_count", a_cnt, 0);
    check("midrst_ovf", a_ovf, 0);
    check("midrst_roll", a_roll, 0);
    check("midrst_b_status", b_status, 0);

`ifdef STOPWATCH_COUNTDOWN_EN
    // Countdown from 0:03 on A.
    mode_down = 1; load_min = 8'd1; load_sec = 6'd63; load = 1;
    step(1);
    load = 0;
    check("load_clamp_min", a_min, 1);
    check("load_clamp_sec", a_sec, 59);
    load_min = 8'd0; load_sec = 6'd3; load = 1;
    step(1);
    load = 0;
    check("load_sec", a_sec, 3);
    ctl(1, 0, 0, 0, 0);
    check("down_status", a_status, 1);
    step(1);
    check("down_2", a_sec, 2);
    step(1);
    check("down_1", a_sec, 1);
    check("down_1_done", a_done, 0);
    step(1);
    check("down_0_sec", a_sec, 0);
    check("down_0_min", a_min, 0);
    check("down_0_status", a_status, 3);
    check("down_0_done", a_done, 1);
    check("down_0_roll", a_roll, 0);
    step(1);
    check("done_hold_status", a_status, 3);
    check("done_pulse_end", a_done, 0);
    check("done_hold_sec", a_sec, 0);
    ctl(1, 0, 0, 0, 0);
    check("done_start_ign", a_status, 3);
    ctl(0, 0, 1, 0, 0);
    check("done_clear", a_status, 0);
    ctl(1, 0, 0, 0, 0);
    check("zero_start_ign", a_status, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
- Parametrised next-generation stopwatch core: MM:SS counter with a configurable prescaler and a lap-capture FIFO.
- Start/stop/clear run control as in the current stopwatch, plus rollover signalling.
- Optional countdown mode.
- Sits below the top-level pushbutton debounce/edge logic; all control inputs are single-cycle pulses from that logic.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per counted second (>=1)
- MIN_WIDTH, 8, minutes counter width (max minutes = 2^MIN_WIDTH-1)
- LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  run/resume pulse
- stop  in  1  pause pulse
- clear  in  1  zero time, empty FIFO, go IDLE
- lap  in  1  capture current time into lap FIFO
- minutes  out  MIN_WIDTH  current minutes
- seconds  out  6  current seconds, 0..59
- status  out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 DONE
- rollover  out  1  one-cycle pulse on wrap from max:59 to 0:00
- lap_valid  out  1  FIFO non-empty
- lap_data  out  MIN_WIDTH+6  FIFO head {minutes,seconds}
- lap_ready  in  1  pop head when lap_valid
- lap_count  out  $clog2(LAP_DEPTH+1)  entries held
- lap_overflow  out  1  sticky: lap dropped because FIFO full

Behaviour:
- Reset (rst high at an edge): status=00, minutes=0, seconds=0, prescaler=0, FIFO empty, lap_valid=0, lap_count=0, lap_overflow=0, rollover=0. Reset mid-run behaves identically.
- Control priority per edge: rst > clear > stop > start.
  - clear acts in any state: time=0, prescaler=0, FIFO emptied, lap_overflow=0, status=IDLE.
- State transitions:
  - IDLE --start--> RUNNING. Prescaler is 0 on entry.
  - RUNNING --stop--> PAUSED. Prescaler value is held, not cleared.
  - PAUSED --start--> RUNNING. Counting resumes from the held prescaler.
  - start while RUNNING and stop while IDLE/PAUSED are ignored.
  - start and stop in the same cycle: stop wins.
- Prescaler:
  - Increments on every RUNNING cycle, including the cycle a stop is sampled? No: on the edge that samples stop, no increment.
  - When prescaler = TICKS_PER_SEC-1, the edge sets it to 0 and advances time by 1 s.
  - First second is visible TICKS_PER_SEC edges after the edge that entered RUNNING. With TICKS_PER_SEC=1, time advances on every RUNNING edge.
- Time arithmetic:
  - seconds 59 -> 0 and minutes +1.
  - At minutes = 2^MIN_WIDTH-1 and seconds = 59, the next tick wraps to 0:00, keeps running, and pulses rollover for exactly one cycle.
- Lap FIFO:
  - lap sampled in RUNNING or PAUSED pushes the pre-edge {minutes,seconds}. lap in IDLE is ignored.
  - Push when full is dropped and lap_overflow=1; it stays 1 until clear or rst.
  - Pop occurs when lap_valid & lap_ready.
  - Simultaneous push and pop when full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop when empty: push only.
  - lap_data is the registered head and is valid whenever lap_valid=1.
  - lap_count is updated on the same edge as push/pop.
  - clear in the same cycle as lap: clear wins, nothing pushed.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: STOPWATCH_COUNTDOWN_EN
- Defined: extra ports are added:
  - mode_down  in  1
  - load  in  1
  - load_min  in  MIN_WIDTH
  - load_sec  in  6
  - done  out  1
- Defined, load behaviour:
  - load accepted only in IDLE; sets time to {load_min, min(load_sec,59)}.
  - Loaded value is retained; load in other states is ignored.
- Defined, countdown behaviour:
  - With mode_down=1, ticks decrement (seconds 0 -> 59 with minutes -1).
  - Reaching 0:00 sets status=DONE and pulses done for one cycle; no further ticks.
  - start while at 0:00 in IDLE is ignored.
  - DONE exits only via clear or rst.
  - mode_down is sampled only on IDLE->RUNNING and held for the run.
  - rollover never pulses in down mode.
- Undefined: the extra ports are absent, count-up only, and status never reads 11.

Test Plan:
- TICKS_PER_SEC=1: rst 2 cycles, start pulse, wait 75 cycles -> minutes=1, seconds=15, status=01.
- TICKS_PER_SEC=4: start, 10 cycles, stop, 20 idle cycles, start, 6 cycles -> seconds=4, prescaler-held check (no lost/extra tick), status 01->10->01.
- MIN_WIDTH=2, TICKS_PER_SEC=1: run 240 seconds -> wraps to 0:00, one-cycle rollover pulse, status stays 01.
- LAP_DEPTH=4: 5 lap pulses at distinct times, lap_ready=0 -> lap_count=4, lap_overflow=1, pops return the first four times in order. Then clear -> lap_valid=0, lap_overflow=0, time 0:00, status=00.
- Simultaneous: start+stop while RUNNING -> PAUSED. clear+lap -> FIFO empty. rst asserted mid-run -> all outputs reset values next cycle.
- STOPWATCH_COUNTDOWN_EN, TICKS_PER_SEC=1: load 0:03, mode_down=1, start -> 0:02, 0:01, 0:00, done pulse, status=11 held; start ignored; clear -> 00.
